// File: rtl/sr_sw_ram_arbiter.sv
// Shares one single-read/single-write RAM between NUM_REQ requesters using two
// independent round-robin arbiters; read data returns one cycle after its grant.
module sr_sw_ram_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 4,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 req_wr,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wr_data,
  output logic [NUM_REQ-1:0]                 gnt_wr,
  input  logic [NUM_REQ-1:0]                 req_rd,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_rd_addr,
  output logic [NUM_REQ-1:0]                 gnt_rd,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]              rsp_data,
  output logic [ADDRESS_WIDTH-1:0]           ram_write_addr,
  output logic [DATA_WIDTH-1:0]              ram_write_data,
  output logic                               ram_write_enable,
  output logic [ADDRESS_WIDTH-1:0]           ram_read_addr,
  output logic                               ram_read_enable,
  input  logic [DATA_WIDTH-1:0]              ram_read_data,
  output logic                               ram_chip_select
);

  localparam int PTR_W = $clog2(NUM_REQ);
  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t                     wr_ptr_r;
  ptr_t                     rd_ptr_r;
  logic [NUM_REQ-1:0]       rsp_valid_r;
  logic [NUM_REQ-1:0]       gnt_wr_s;
  logic [NUM_REQ-1:0]       gnt_rd_s;
  logic [ADDRESS_WIDTH-1:0] wr_addr_s;
  logic [DATA_WIDTH-1:0]    wr_data_s;
  logic [ADDRESS_WIDTH-1:0] rd_addr_s;

  // An out-of-range pointer (upset) is treated as 0 so arbitration stays fair.
  function automatic ptr_t legal_ptr(input ptr_t ptr);
    return (ptr <= ptr_t'(NUM_REQ - 1)) ? ptr : ptr_t'(0);
  endfunction

  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input ptr_t ptr);
    logic [NUM_REQ-1:0] gnt;
    ptr_t               idx;
    logic               found;
    gnt   = '0;
    found = 1'b0;
    idx   = legal_ptr(ptr);
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end else begin
        found = found;
      end
      idx = (idx == ptr_t'(NUM_REQ - 1)) ? ptr_t'(0) : idx + ptr_t'(1);
    end
    return gnt;
  endfunction

  function automatic ptr_t next_ptr(input logic [NUM_REQ-1:0] gnt, input ptr_t ptr);
    ptr_t nxt;
    nxt = legal_ptr(ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        nxt = (k == NUM_REQ - 1) ? ptr_t'(0) : ptr_t'(k + 1);
      end else begin
        nxt = nxt;
      end
    end
    return nxt;
  endfunction

  // Grants are held off while reset is asserted.
  always_comb begin
    gnt_wr_s = reset_n ? rr_pick(req_wr, wr_ptr_r) : '0;
    gnt_rd_s = reset_n ? rr_pick(req_rd, rd_ptr_r) : '0;
  end

  // AND-OR mux of the granted slices; zero when nothing is granted.
  always_comb begin
    wr_addr_s = '0;
    wr_data_s = '0;
    rd_addr_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      wr_addr_s = wr_addr_s |
                  (req_wr_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH] & {ADDRESS_WIDTH{gnt_wr_s[k]}});
      wr_data_s = wr_data_s |
                  (req_wr_data[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt_wr_s[k]}});
      rd_addr_s = rd_addr_s |
                  (req_rd_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH] & {ADDRESS_WIDTH{gnt_rd_s[k]}});
    end
  end

  // Round-robin pointers and the one-cycle-delayed read response tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      rsp_valid_r <= '0;
    end else begin
      wr_ptr_r    <= next_ptr(gnt_wr_s, wr_ptr_r);
      rd_ptr_r    <= next_ptr(gnt_rd_s, rd_ptr_r);
      rsp_valid_r <= gnt_rd_s;
    end
  end

  assign gnt_wr           = gnt_wr_s;
  assign gnt_rd           = gnt_rd_s;
  assign rsp_valid        = rsp_valid_r;
  assign rsp_data         = ram_read_data;
  assign ram_write_addr   = wr_addr_s;
  assign ram_write_data   = wr_data_s;
  assign ram_write_enable = |gnt_wr_s;
  assign ram_read_addr    = rd_addr_s;
  assign ram_read_enable  = |gnt_rd_s;
  assign ram_chip_select  = (|gnt_wr_s) | (|gnt_rd_s);

endmodule

// File: tb/tb_sr_sw_ram_arbiter.sv
// Randomized and directed bench for sr_sw_ram_arbiter against a round-robin
// reference model and a read-first RAM model.
module tb_sr_sw_ram_arbiter;

  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef logic [N*AW-1:0] av_t;
  typedef logic [N*DW-1:0] dv_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req_wr, gnt_wr, req_rd, gnt_rd, rsp_valid;
  av_t           req_wr_addr, req_rd_addr;
  dv_t           req_wr_data;
  logic [DW-1:0] rsp_data, ram_write_data, ram_read_data;
  logic [AW-1:0] ram_write_addr, ram_read_addr;
  logic          ram_write_enable, ram_read_enable, ram_chip_select;

  always #5 clk = ~clk;

  sr_sw_ram_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_wr(req_wr), .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data), .gnt_wr(gnt_wr),
    .req_rd(req_rd), .req_rd_addr(req_rd_addr), .gnt_rd(gnt_rd),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
    .ram_write_enable(ram_write_enable), .ram_read_addr(ram_read_addr),
    .ram_read_enable(ram_read_enable), .ram_read_data(ram_read_data),
    .ram_chip_select(ram_chip_select)
  );

  // Read-first RAM with one cycle of read latency.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_read_enable) ram_read_data <= ram_mem[ram_read_addr];
    if (ram_write_enable) ram_mem[ram_write_addr] <= ram_write_data;
  end

  // Reference model state
  int            ref_wr_ptr, ref_rd_ptr;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [N-1:0]  exp_rsp_valid;
  logic [DW-1:0] exp_rsp_data;
  int            n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int bit_of(input logic [N-1:0] v, input int i);
    return int'((v >> i) & N'(1));
  endfunction

  function automatic logic [AW-1:0] sl_a(input av_t v, input int i);
    return AW'(v >> (i * AW));
  endfunction

  function automatic logic [DW-1:0] sl_d(input dv_t v, input int i);
    return DW'(v >> (i * DW));
  endfunction

  // First requester at or after ptr, wrapping modulo N; -1 if none.
  function automatic int rr_winner(input logic [N-1:0] req, input int ptr);
    for (int off = 0; off < N; off++)
      if (bit_of(req, (ptr + off) % N) == 1) return (ptr + off) % N;
    return -1;
  endfunction

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr      = req_wr | N'(32'd1 << i);
    req_wr_addr = (req_wr_addr & ~(av_t'({AW{1'b1}}) << (i * AW))) | (av_t'(a) << (i * AW));
    req_wr_data = (req_wr_data & ~(dv_t'({DW{1'b1}}) << (i * DW))) | (dv_t'(d) << (i * DW));
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    req_rd      = req_rd | N'(32'd1 << i);
    req_rd_addr = (req_rd_addr & ~(av_t'({AW{1'b1}}) << (i * AW))) | (av_t'(a) << (i * AW));
  endtask

  task automatic clr_all();
    req_wr = '0;
    req_rd = '0;
  endtask

  task automatic model_reset();
    ref_wr_ptr    = 0;
    ref_rd_ptr    = 0;
    exp_rsp_valid = '0;
  endtask

  // Check one cycle's combinational outputs, model the edge, check the response.
  task automatic step(output int wk, output int rk);
    logic [31:0]   eg;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    wa = '0; ra = '0; wd = '0;
    #1;
    wk = rr_winner(req_wr, ref_wr_ptr);
    rk = rr_winner(req_rd, ref_rd_ptr);
    eg = (wk < 0) ? 32'd0 : (32'd1 << wk);
    check_eq("gnt_wr", 32'(gnt_wr), eg);
    eg = (rk < 0) ? 32'd0 : (32'd1 << rk);
    check_eq("gnt_rd", 32'(gnt_rd), eg);
    check_eq("wr_en", 32'(ram_write_enable), 32'(wk >= 0));
    check_eq("rd_en", 32'(ram_read_enable), 32'(rk >= 0));
    check_eq("cs", 32'(ram_chip_select), 32'((wk >= 0) || (rk >= 0)));
    if (wk >= 0) begin
      wa = sl_a(req_wr_addr, wk);
      wd = sl_d(req_wr_data, wk);
      check_eq("wr_addr", 32'(ram_write_addr), 32'(wa));
      check_eq("wr_data", 32'(ram_write_data), 32'(wd));
    end
    if (rk >= 0) begin
      ra = sl_a(req_rd_addr, rk);
      check_eq("rd_addr", 32'(ram_read_addr), 32'(ra));
    end
    exp_rsp_valid = (rk < 0) ? '0 : N'(32'd1 << rk);
    if (rk >= 0) begin
      exp_rsp_data = ref_mem[ra];
      ref_rd_ptr   = (rk + 1) % N;
    end
    if (wk >= 0) begin
      ref_mem[wa] = wd;
      ref_wr_ptr  = (wk + 1) % N;
    end
    @(negedge clk);
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
    if (exp_rsp_valid != '0) check_eq("rsp_data", 32'(rsp_data), 32'(exp_rsp_data));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wk, rk;
    logic [N-1:0] seq [4];
    seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    for (int a = 0; a < DEPTH; a++) begin
      ram_mem[a] = '0;
      ref_mem[a] = '0;
    end
    reset_n     = 1'b0;
    req_wr      = '1;
    req_rd      = '1;
    req_wr_addr = av_t'($urandom);
    req_rd_addr = av_t'($urandom);
    req_wr_data = dv_t'({$urandom, $urandom});
    model_reset();

    // Held in reset with every request asserted
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      check_eq("rst_gnt_wr", 32'(gnt_wr), 32'd0);
      check_eq("rst_gnt_rd", 32'(gnt_rd), 32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_en", 32'({ram_write_enable, ram_read_enable, ram_chip_select}), 32'd0);
    end
    clr_all();
    reset_n = 1'b1;

    // Write by req1 then read back by req0
    set_wr(1, 2'd2, 8'hA5);
    #1 check_eq("t2_gnt_wr", 32'(gnt_wr), 32'(3'b010));
    step(wk, rk);
    clr_all();
    set_rd(0, 2'd2);
    #1 check_eq("t2_gnt_rd", 32'(gnt_rd), 32'(3'b001));
    step(wk, rk);
    check_eq("t2_rsp_valid", 32'(rsp_valid), 32'(3'b001));
    check_eq("t2_rsp_data", 32'(rsp_data), 32'h A5);

    // Rotation with all writers requesting from a fresh pointer
    clr_all();
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    model_reset();
    req_wr = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #1 check_eq("t3_rotate", 32'(gnt_wr), 32'(seq[c]));
      step(wk, rk);
    end

    // After req1 is served, req2 comes before req0
    clr_all();
    set_rd(1, 2'd0);
    step(wk, rk);
    req_rd = 3'b101;
    #1 check_eq("t4_first", 32'(gnt_rd), 32'(3'b100));
    step(wk, rk);
    #1 check_eq("t4_second", 32'(gnt_rd), 32'(3'b001));
    step(wk, rk);

    // Same-cycle write and read of one address returns the old word
    clr_all();
    set_wr(0, 2'd1, 8'h11);
    step(wk, rk);
    clr_all();
    set_wr(0, 2'd1, 8'h22);
    set_rd(2, 2'd1);
    step(wk, rk);
    check_eq("t5_rsp_valid", 32'(rsp_valid), 32'(3'b100));
    check_eq("t5_old_word", 32'(rsp_data), 32'h11);
    clr_all();
    set_rd(2, 2'd1);
    step(wk, rk);
    check_eq("t5_new_word", 32'(rsp_data), 32'h22);

    // Reset between a read grant and its response
    clr_all();
    set_rd(1, 2'd3);
    #1 check_eq("t6_gnt_rd", 32'(gnt_rd), 32'(3'b010));
    reset_n = 1'b0;
    #1 check_eq("t6_gnt_in_rst", 32'(gnt_rd), 32'd0);
    @(posedge clk); #1;
    check_eq("t6_rsp_dropped", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("t6_rsp_still0", 32'(rsp_valid), 32'd0);
    model_reset();
    reset_n = 1'b1;
    req_rd  = 3'b111;
    #1 check_eq("t6_ptr_reset", 32'(gnt_rd), 32'(3'b001));
    step(wk, rk);

    // Random traffic; each requester holds its request until granted
    clr_all();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (bit_of(req_wr, i) == 0 && $urandom_range(0, 1) == 1)
          set_wr(i, AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
        if (bit_of(req_rd, i) == 0 && $urandom_range(0, 1) == 1)
          set_rd(i, AW'($urandom_range(0, DEPTH - 1)));
      end
      step(wk, rk);
      if (wk >= 0) req_wr = req_wr & ~N'(32'd1 << wk);
      if (rk >= 0) req_rd = req_rd & ~N'(32'd1 << rk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
